seven_seg_scan_decoder: RTL and testbench

//  Receive-side counterpart of the 4-digit multiplexed 7-segment driver.
//  - Samples SEG_ANODE/SEG_CATHODE and rebuilds the 4 BCD digits as a 16-bit word.
//  - Used for loopback self-checking in simulation and on-board scan monitoring.
//  - Sits directly on the driver's output pins; its output word mirrors the driver's bcd_out input.

---
 rtl/seg7_pkg.sv | 59 +++++
 rtl/seg7_pattern_decode.sv | 41 ++++
 rtl/seven_seg_scan_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_seven_seg_scan_decoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: definitions shared by the 7-segment scan driver and receiver.
//   - Segment bit order: bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f,
//     bit6=g. Patterns below are active-high ({g..a}).
//   - SEG_0..SEG_F glyph patterns for BCD and hex digits.
//   - Scan receiver FSM state encoding.
//   - onehot_to_index: digit position of a one-hot anode vector.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NIBBLE_W   = 4;

  // Segment bit positions within a pattern
  localparam int unsigned SEG_BIT_A = 0;
  localparam int unsigned SEG_BIT_B = 1;
  localparam int unsigned SEG_BIT_C = 2;
  localparam int unsigned SEG_BIT_D = 3;
  localparam int unsigned SEG_BIT_E = 4;
  localparam int unsigned SEG_BIT_F = 5;
  localparam int unsigned SEG_BIT_G = 6;

  // Glyph patterns, active-high {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F = 7'h71;

  // Nibble stored for a pattern that does not decode
  localparam logic [NIBBLE_W-1:0] NIBBLE_INVALID = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } scan_state_e;

  // Highest set bit wins; callers only rely on the result for one-hot input.
  function automatic logic [1:0] onehot_to_index(input logic [NUM_DIGITS-1:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational 7-segment pattern -> nibble decoder.
//   pattern : in  7  active-high segment pattern {g..a}
//   valid   : out 1  pattern is a recognised glyph
//   nibble  : out 4  decoded value; 4'hF when the pattern is not recognised
// Configuration macro HEX_DECODE_EN: when defined, the A..F glyphs are also
// recognised; otherwise only 0..9 decode and A..F count as invalid.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0]    pattern,
  output logic                valid,
  output logic [NIBBLE_W-1:0] nibble
);

  always_comb begin
    valid  = 1'b1;
    nibble = NIBBLE_INVALID;
    case (pattern)
      SEG_0: nibble = 4'h0;
      SEG_1: nibble = 4'h1;
      SEG_2: nibble = 4'h2;
      SEG_3: nibble = 4'h3;
      SEG_4: nibble = 4'h4;
      SEG_5: nibble = 4'h5;
      SEG_6: nibble = 4'h6;
      SEG_7: nibble = 4'h7;
      SEG_8: nibble = 4'h8;
      SEG_9: nibble = 4'h9;
`ifdef HEX_DECODE_EN
      SEG_A: nibble = 4'hA;
      SEG_B: nibble = 4'hB;
      SEG_C: nibble = 4'hC;
      SEG_D: nibble = 4'hD;
      SEG_E: nibble = 4'hE;
      SEG_F: nibble = 4'hF;
`endif
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder: receive side of a 4-digit multiplexed 7-segment
// scan. Watches the anode/cathode pins and rebuilds the displayed BCD word.
//   clk         : in  1   rising-edge clock
//   rst         : in  1   asynchronous active-high reset
//   SEG_ANODE   : in  4   digit enables, bit k = digit k (digit 3 = bcd_in[15:12])
//   SEG_CATHODE : in  7   segments, bit0=a .. bit6=g
//   bcd_in      : out 16  last complete frame {d3,d2,d1,d0}
//   frame_valid : out 1   one-cycle pulse when bcd_in updates
//   frame_err   : out 1   with frame_valid: some digit of the frame did not decode
//   anode_err   : out 1   one-cycle pulse when more than one anode becomes active
// Parameters: SETTLE_CYCLES (stable synced cycles before capture, >=1),
//             ACTIVE_LOW (1: pins active-low, 0: active-high).
// Configuration macro HEX_DECODE_EN (handled in seg7_pattern_decode) adds
// A..F glyph decoding.
module seven_seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_DIGITS-1:0] SEG_ANODE,
  input  logic [SEG_W-1:0]      SEG_CATHODE,
  output logic [15:0]           bcd_in,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  anode_err
);

  localparam int unsigned    CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  // Pin normalisation and synchroniser
  logic [NUM_DIGITS-1:0] anode_norm;
  logic [SEG_W-1:0]      cath_norm;

  logic [NUM_DIGITS-1:0] anode_s1_q, anode_s1_d;
  logic [NUM_DIGITS-1:0] anode_s2_q, anode_s2_d;
  logic [NUM_DIGITS-1:0] anode_prev_q, anode_prev_d;
  logic [SEG_W-1:0]      cath_s1_q, cath_s1_d;
  logic [SEG_W-1:0]      cath_s2_q, cath_s2_d;
  logic [SEG_W-1:0]      cath_prev_q, cath_prev_d;

  always_comb begin
    anode_norm   = ACTIVE_LOW ? ~SEG_ANODE : SEG_ANODE;
    cath_norm    = ACTIVE_LOW ? ~SEG_CATHODE : SEG_CATHODE;
    anode_s1_d   = anode_norm;
    anode_s2_d   = anode_s1_q;
    anode_prev_d = anode_s2_q;
    cath_s1_d    = cath_norm;
    cath_s2_d    = cath_s1_q;
    cath_prev_d  = cath_s2_q;
  end

  // Change detection and anode classification on the synced values
  logic       anode_chg;
  logic       cath_chg;
  logic       change;
  logic       multi_hot;
  logic       one_hot;
  logic [1:0] digit_idx;

  always_comb begin
    anode_chg = (anode_s2_q != anode_prev_q);
    cath_chg  = (cath_s2_q != cath_prev_q);
    change    = anode_chg | cath_chg;
    multi_hot = ((anode_s2_q & (anode_s2_q - NUM_DIGITS'(1))) != '0);
    one_hot   = (anode_s2_q != '0) && !multi_hot;
    digit_idx = onehot_to_index(anode_s2_q);
  end

  logic                dec_valid;
  logic [NIBBLE_W-1:0] dec_nibble;

  seg7_pattern_decode u_decode (
    .pattern (cath_s2_q),
    .valid   (dec_valid),
    .nibble  (dec_nibble)
  );

  // Scan FSM, settle counter and frame assembly
  scan_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Set once the current anode dwell has produced a capture; cleared on any
  // anode change so a cathode glitch inside a dwell cannot recapture.
  logic dwell_done_q, dwell_done_d;
  logic capture;

  logic [NUM_DIGITS-1:0]               mask_q, mask_d;
  logic [NUM_DIGITS-1:0][NIBBLE_W-1:0] shadow_q, shadow_d;
  logic                                err_acc_q, err_acc_d;
  logic                                frame_done;

  logic [15:0] bcd_q, bcd_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        anode_err_q, anode_err_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dwell_done_d = dwell_done_q;
    capture      = 1'b0;
    // Only a fresh multi-anode condition is reported, not every cycle it persists.
    anode_err_d  = multi_hot & anode_chg;

    if (anode_chg) dwell_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (one_hot) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (change) begin
          cnt_d   = '0;
          state_d = one_hot ? SETTLE : IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          capture = !dwell_done_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (change) begin
          cnt_d   = '0;
          state_d = one_hot ? SETTLE : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (capture) dwell_done_d = 1'b1;

    // Frame completion publishes the old shadow while a coincident capture
    // starts the next frame's mask and error accumulator.
    frame_done    = (mask_q == '1);
    bcd_d         = frame_done ? shadow_q : bcd_q;
    frame_valid_d = frame_done;
    frame_err_d   = frame_done & err_acc_q;
    mask_d        = frame_done ? '0 : mask_q;
    err_acc_d     = frame_done ? 1'b0 : err_acc_q;
    shadow_d      = shadow_q;

    if (capture) begin
      shadow_d[digit_idx] = dec_nibble;
      mask_d[digit_idx]   = 1'b1;
      err_acc_d           = err_acc_d | !dec_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode_s1_q    <= '0;
      anode_s2_q    <= '0;
      anode_prev_q  <= '0;
      cath_s1_q     <= '0;
      cath_s2_q     <= '0;
      cath_prev_q   <= '0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      dwell_done_q  <= 1'b0;
      mask_q        <= '0;
      shadow_q      <= '0;
      err_acc_q     <= 1'b0;
      bcd_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      anode_err_q   <= 1'b0;
    end else begin
      anode_s1_q    <= anode_s1_d;
      anode_s2_q    <= anode_s2_d;
      anode_prev_q  <= anode_prev_d;
      cath_s1_q     <= cath_s1_d;
      cath_s2_q     <= cath_s2_d;
      cath_prev_q   <= cath_prev_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dwell_done_q  <= dwell_done_d;
      mask_q        <= mask_d;
      shadow_q      <= shadow_d;
      err_acc_q     <= err_acc_d;
      bcd_q         <= bcd_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      anode_err_q   <= anode_err_d;
    end
  end

  assign bcd_in      = bcd_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign anode_err   = anode_err_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Testbench for seven_seg_scan_decoder (SETTLE_CYCLES=4, active-low pins).
// Scans digits onto the pins directly; each frame's expected word is queued
// when its scan starts and a monitor pops it on every frame_valid.
module tb_seven_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  SEG_ANODE;
  logic [6:0]  SEG_CATHODE;
  logic [15:0] bcd_in;
  logic        frame_valid;
  logic        frame_err;
  logic        anode_err;

  always #5 clk = ~clk;

  seven_seg_scan_decoder #(
    .SETTLE_CYCLES (4),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .SEG_ANODE   (SEG_ANODE),
    .SEG_CATHODE (SEG_CATHODE),
    .bcd_in      (bcd_in),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .anode_err   (anode_err)
  );

  typedef struct packed {
    logic [15:0] bcd;
    logic        err;
  } frame_t;

  frame_t exp_q[$];
  int total       = 0;
  int bad         = 0;
  int n_frames    = 0;
  int n_anode_err = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endfunction

  // Active-high glyphs {g..a}
  function automatic logic [6:0] pat_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      default: return 7'h00;
    endcase
  endfunction

  // Monitor: every frame_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    frame_t e;
    if (rst === 1'b0) begin
      if (anode_err === 1'b1) n_anode_err++;
      if (frame_valid === 1'b1) begin
        n_frames++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got bcd_in=%h, want no frame", bcd_in);
        end else begin
          e = exp_q.pop_front();
          check("frame_bcd", 32'(bcd_in), 32'(e.bcd));
          check("frame_err", 32'(frame_err), 32'(e.err));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive digit k with an active-high pattern; pins are active-low.
  task automatic show(input int k, input logic [6:0] pat, input int cycles);
    SEG_ANODE   = ~(4'b0001 << k);
    SEG_CATHODE = ~pat;
    tick(cycles);
  endtask

  task automatic blank();
    SEG_ANODE   = 4'hF;
    SEG_CATHODE = 7'h7F;
    tick(2);
  endtask

  task automatic scan(input logic [15:0] v);
    for (int k = 0; k < 4; k++) begin
      show(k, pat_of(v[k*4 +: 4]), 10);
      blank();
    end
  endtask

  task automatic expect_frame(input logic [15:0] v, input logic err);
    frame_t f;
    f.bcd = v;
    f.err = err;
    exp_q.push_back(f);
  endtask

  int frames_before;

  initial begin
    rst         = 1'b1;
    SEG_ANODE   = 4'hF;
    SEG_CATHODE = 7'h7F;
    tick(3);
    check("reset_bcd_in", 32'(bcd_in), 32'h0);
    check("reset_frame_valid", 32'(frame_valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_anode_err", 32'(anode_err), 32'h0);
    rst = 1'b0;
    tick(3);

    // Plain frame
    expect_frame(16'h1842, 1'b0);
    scan(16'h1842);

    // Value switches after digit 1: this frame mixes, the next is clean
    expect_frame(16'h1042, 1'b0);
    show(0, pat_of(4'h2), 10); blank();
    show(1, pat_of(4'h4), 10); blank();
    show(2, pat_of(4'h0), 10); blank();
    show(3, pat_of(4'h1), 10); blank();
    expect_frame(16'h1023, 1'b0);
    scan(16'h1023);

    // Glitches on digit 0: 3-cycle '8' at dwell start, 2-cycle '8' mid-dwell
    expect_frame(16'h9375, 1'b0);
    show(0, pat_of(4'h8), 3);
    show(0, pat_of(4'h5), 10);
    show(0, pat_of(4'h8), 2);
    show(0, pat_of(4'h5), 8);
    blank();
    show(1, pat_of(4'h7), 10); blank();
    show(2, pat_of(4'h3), 10); blank();
    show(3, pat_of(4'h9), 10); blank();

    // Two anodes mid-frame: one anode_err, captured digits survive
    expect_frame(16'h0816, 1'b0);
    show(0, pat_of(4'h6), 10); blank();
    show(1, pat_of(4'h1), 10);
    SEG_ANODE = 4'b1100;
    tick(10);
    blank();
    show(2, pat_of(4'h8), 10); blank();
    show(3, pat_of(4'h0), 10); blank();

    // Hex glyph 'A' on digit 2
`ifdef HEX_DECODE_EN
    expect_frame(16'h7A24, 1'b0);
`else
    expect_frame(16'h7F24, 1'b1);
`endif
    show(0, pat_of(4'h4), 10); blank();
    show(1, pat_of(4'h2), 10); blank();
    show(2, pat_of(4'hA), 10); blank();
    show(3, pat_of(4'h7), 10); blank();

    // Reset after 3 captures; next frame needs 4 fresh captures
    show(0, pat_of(4'h3), 10); blank();
    show(1, pat_of(4'h3), 10); blank();
    show(2, pat_of(4'h3), 10); blank();
    rst = 1'b1;
    tick(2);
    check("midreset_bcd_in", 32'(bcd_in), 32'h0);
    check("midreset_frame_valid", 32'(frame_valid), 32'h0);
    check("midreset_frame_err", 32'(frame_err), 32'h0);
    check("midreset_anode_err", 32'(anode_err), 32'h0);
    rst = 1'b0;
    tick(2);
    frames_before = n_frames;
    show(1, pat_of(4'h5), 10); blank();
    show(2, pat_of(4'h6), 10); blank();
    show(3, pat_of(4'h9), 10); blank();
    check("no_frame_after_3_captures", 32'(n_frames), 32'(frames_before));
    expect_frame(16'h9658, 1'b0);
    show(0, pat_of(4'h8), 10); blank();

    tick(5);
    check("all_frames_seen", 32'(exp_q.size()), 32'h0);
    check("anode_err_pulses", 32'(n_anode_err), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
